// File: rtl/rvfi_bus_dmem_write_check.sv
// ---------------------------------------------------------------------------
// rvfi_bus_dmem_write_check
//   Write-direction checker for the RVFI bus channel. Every byte that a
//   retired store writes to the watched word (dmem_addr) must later appear on
//   the data-side bus with the same value, within MAX_LAT cycles.
//
// Ports
//   clock / reset     sampling clock, asynchronous active-low reset
//   check             enables the embedded assertion this cycle
//   dmem_addr         watched XLEN-aligned word address (held by harness)
//   rvfi_valid        retire valid, one bit per retire channel
//   rvfi_mem_addr     retire memory address, NRET x XLEN
//   rvfi_mem_wmask    retire write byte mask, NRET x XLEN/8
//   rvfi_mem_wdata    retire write data, NRET x XLEN
//   rvfi_bus_valid    bus transfer valid, one bit per bus channel
//   rvfi_bus_data     1 = data-side transfer, 0 = instruction fetch
//   rvfi_bus_addr     bus byte address of lane 0, NBUS x XLEN
//   rvfi_bus_wmask    bus write byte mask, NBUS x BUSLEN/8
//   rvfi_bus_wdata    bus write data, NBUS x BUSLEN
//   pend_mask         bytes retired but not yet seen on the bus
//   err_data          sticky: bus wrote a pending byte with the wrong value
//   err_timeout       sticky: bytes pending for MAX_LAT consecutive cycles
//   drained           one-cycle pulse: pending set emptied without error
// ---------------------------------------------------------------------------
module rvfi_bus_dmem_write_check #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned BUSLEN  = 32,
  parameter int unsigned NRET    = 1,
  parameter int unsigned NBUS    = 1,
  parameter int unsigned MAX_LAT = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       check,
  input  logic [XLEN-1:0]            dmem_addr,
  input  logic [NRET-1:0]            rvfi_valid,
  input  logic [NRET*XLEN-1:0]       rvfi_mem_addr,
  input  logic [NRET*XLEN/8-1:0]     rvfi_mem_wmask,
  input  logic [NRET*XLEN-1:0]       rvfi_mem_wdata,
  input  logic [NBUS-1:0]            rvfi_bus_valid,
  input  logic [NBUS-1:0]            rvfi_bus_data,
  input  logic [NBUS*XLEN-1:0]       rvfi_bus_addr,
  input  logic [NBUS*BUSLEN/8-1:0]   rvfi_bus_wmask,
  input  logic [NBUS*BUSLEN-1:0]     rvfi_bus_wdata,
  output logic [XLEN/8-1:0]          pend_mask,
  output logic                       err_data,
  output logic                       err_timeout,
  output logic                       drained
);

  localparam int unsigned NB      = XLEN / 8;
  localparam int unsigned BB      = BUSLEN / 8;
  localparam int unsigned IDX_W   = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned LAT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam int unsigned LAT_LIM = (MAX_LAT > 0) ? (MAX_LAT - 1) : 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [NB-1:0]          pend_q, pend_d;
  logic [NB-1:0][7:0]     exp_q, exp_d;
  logic [LAT_W-1:0]       lat_q, lat_d;
  logic                   err_data_q, err_data_d;
  logic                   err_to_q, err_to_d;
  logic                   drained_q, drained_d;

  logic                   added_c;
  logic                   mismatch_c;
  logic                   timeout_c;
  logic [XLEN-1:0]        off_c;

  // Byte tracking: retire channels first, then bus channels, so a store and
  // a matching bus write in the same cycle cancel out.
  always_comb begin
    pend_d     = pend_q;
    exp_d      = exp_q;
    added_c    = 1'b0;
    mismatch_c = 1'b0;
    off_c      = '0;

    for (int c = 0; c < int'(NRET); c++) begin
      if (rvfi_valid[c] && (rvfi_mem_addr[c*XLEN +: XLEN] == dmem_addr)) begin
        for (int j = 0; j < int'(NB); j++) begin
          if (rvfi_mem_wmask[c*NB + j]) begin
            exp_d[j]  = rvfi_mem_wdata[c*XLEN + j*8 +: 8];
            pend_d[j] = 1'b1;
            added_c   = 1'b1;
          end
        end
      end
    end

    for (int b = 0; b < int'(NBUS); b++) begin
      for (int i = 0; i < int'(BB); i++) begin
        if (rvfi_bus_valid[b] && rvfi_bus_data[b] && rvfi_bus_wmask[b*BB + i]) begin
          // Offset of this lane relative to the watched word, modulo 2^XLEN.
          off_c = rvfi_bus_addr[b*XLEN +: XLEN] + XLEN'(i) - dmem_addr;
          if ((off_c < XLEN'(NB)) && pend_d[off_c[IDX_W-1:0]]) begin
            if (rvfi_bus_wdata[b*BUSLEN + i*8 +: 8] != exp_d[off_c[IDX_W-1:0]]) begin
              mismatch_c = 1'b1;
            end
            pend_d[off_c[IDX_W-1:0]] = 1'b0;
          end
          // Writes to bytes that are not pending are evictions of older data.
        end
      end
    end
  end

  // Timeout fires on the last allowed waiting cycle with bytes still pending.
  always_comb begin
    timeout_c = 1'b0;
    if ((MAX_LAT != 0) && (state_q == S_WAIT) && !added_c &&
        (lat_q == LAT_W'(LAT_LIM)) && (pend_d != '0)) begin
      timeout_c = 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (mismatch_c || timeout_c) begin
          state_d = S_ERR;
        end else if (pend_d != '0) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mismatch_c || timeout_c) begin
          state_d = S_ERR;
        end else if (pend_d == '0) begin
          state_d = S_IDLE;
        end
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  // FSM output and latency-counter next values.
  always_comb begin
    err_data_d = err_data_q | mismatch_c;
    err_to_d   = err_to_q | timeout_c;
    drained_d  = 1'b0;
    lat_d      = lat_q;

    // Leaving WAIT for IDLE implies no error flag is set (errors go to ERR).
    if ((state_q == S_WAIT) && (state_d == S_IDLE)) begin
      drained_d = 1'b1;
    end

    if ((state_q == S_IDLE) || added_c) begin
      lat_d = '0;
    end else if ((state_q == S_WAIT) && (lat_q != '1)) begin
      lat_d = lat_q + LAT_W'(1);
    end
  end

  // Datapath and status registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_q     <= '0;
      exp_q      <= '0;
      lat_q      <= '0;
      err_data_q <= 1'b0;
      err_to_q   <= 1'b0;
      drained_q  <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      exp_q      <= exp_d;
      lat_q      <= lat_d;
      err_data_q <= err_data_d;
      err_to_q   <= err_to_d;
      drained_q  <= drained_d;
    end
  end

  assign pend_mask   = pend_q;
  assign err_data    = err_data_q;
  assign err_timeout = err_to_q;
  assign drained     = drained_q;

  // Formal hooks: no error while checking is enabled; reachability of a drain.
  a_no_err: assert property (@(posedge clock) disable iff (!reset)
                             check |-> (!err_data && !err_timeout));
  c_drained: cover property (@(posedge clock) disable iff (!reset)
                             check && drained);

endmodule
